// File: rtl/col_fifo_arbiter.sv
// rtl/col_fifo_arbiter.sv - round-robin arbiter draining four column FIFOs into one output stream
//
// Ports:
//   clk_40MHz, rst_n      clock, asynchronous active-low reset
//   arb_en                allows new grants from IDLE
//   fifo_empty[i]         column i has nothing to read when high
//   fifo_data             packed column words, column i at [i*DATA_W +: DATA_W]
//   rd_en                 registered one-hot read strobe, high only in READ
//   out_valid/out_ready   output handshake, out_data = {column, word}
//   busy                  high whenever the FSM is not in IDLE
//   cnt_clr, word_cnt     clear / saturating count of accepted words
`timescale 1ns/1ps
module col_fifo_arbiter #(
    parameter int NUM_COL = 4,
    parameter int DATA_W  = 28,
    parameter int GAP_CYC = 2
) (
    input  logic                      clk_40MHz,
    input  logic                      rst_n,
    input  logic                      arb_en,
    input  logic [NUM_COL-1:0]        fifo_empty,
    input  logic [NUM_COL*DATA_W-1:0] fifo_data,
    output logic [NUM_COL-1:0]        rd_en,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W+1:0]         out_data,
    output logic                      busy,
    input  logic                      cnt_clr,
    output logic [15:0]               word_cnt
);

    typedef enum logic [1:0] {IDLE, READ, SEND, GAP} state_t;

    state_t              state, state_d;
    logic [1:0]          last_grant;
    logic [1:0]          grant_q;
    logic [1:0]          pick;
    logic [1:0]          rr_idx;
    logic                req_any;
    logic [1:0]          gap_cnt;
    logic [DATA_W+1:0]   hold_q;
    logic [DATA_W-1:0]   col_words [NUM_COL];

    always_comb begin
        for (int c = 0; c < NUM_COL; c++) begin
            col_words[c] = fifo_data[c*DATA_W +: DATA_W];
        end
    end

    // Search starts one past the last grant; k = NUM_COL wraps back to
    // last_grant itself so a lone requester can be served repeatedly.
    always_comb begin
        pick    = last_grant;
        rr_idx  = last_grant;
        req_any = 1'b0;
        for (int k = 1; k <= NUM_COL; k++) begin
            rr_idx = last_grant + 2'(k);
            if (!req_any && !fifo_empty[rr_idx]) begin
                pick    = rr_idx;
                req_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (arb_en && req_any) state_d = READ;
            READ: state_d = (col_words[grant_q] != '0) ? SEND : GAP;
            SEND: if (out_ready) state_d = GAP;
            GAP:  if (gap_cnt <= 2'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The holding register doubles as out_data; out_valid qualifies it, so a
    // captured zero word sits there harmlessly with out_valid low.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            rd_en      <= '0;
            out_valid  <= 1'b0;
            hold_q     <= '0;
            grant_q    <= 2'd0;
            last_grant <= 2'd3;
            gap_cnt    <= 2'd0;
        end else begin
            rd_en <= '0;
            case (state)
                IDLE: begin
                    if (state_d == READ) begin
                        grant_q    <= pick;
                        last_grant <= pick;
                        rd_en      <= NUM_COL'(1) << pick;
                    end
                end
                READ: begin
                    hold_q <= {grant_q, col_words[grant_q]};
                    if (state_d == SEND) begin
                        out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= 2'(GAP_CYC);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gap_cnt   <= 2'(GAP_CYC);
                    end
                end
                GAP: begin
                    gap_cnt <= (gap_cnt > 2'd1) ? gap_cnt - 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 16'd0;
        end else if (cnt_clr) begin
            word_cnt <= 16'd0;
        end else if (state == SEND && out_ready && word_cnt != 16'hFFFF) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

    assign out_data = hold_q;
    assign busy     = (state != IDLE);

endmodule
